// File: rtl/tx_arbiter_if.sv
// ============================================================================
// Module  : tx_arbiter_if
// Brief   : Requester/Transmiter-side signal bundle of the tx_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req;
  logic [10*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]    ack;
  logic                  start;
  logic [9:0]            swout;
  logic                  busy;
  logic [OW-1:0]         owner;

  // master = requesters / observers, slave = the arbiter itself
  modport master (
    output req, data,
    input  ack, start, swout, busy, owner
  );

  modport slave (
    input  req, data,
    output ack, start, swout, busy, owner
  );
endinterface

`default_nettype wire

// File: rtl/tx_arbiter.sv
// ============================================================================
// Module  : tx_arbiter
// Brief   : Round-robin scheduler sharing one serial Transmiter between
//           NUM_REQ requesters; holds the link for frame + gap per grant.
//           Define TX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 5500,
  parameter int GAP_CYCLES   = 500
) (
  input logic         clk_i,
  input logic         rst_ni,
  tx_arbiter_if.slave bus
);

  localparam int OW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] C_FRAME_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [OW:0]   C_NUM_REQ    = (OW + 1)'(NUM_REQ);
  localparam logic [OW-1:0] C_LAST       = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [9:0]           swout_q, swout_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic [OW-1:0]        owner_q, owner_d;

  logic [OW-1:0]        w_ptr;
  logic [OW-1:0]        w_winner;
  logic                 w_found;
  logic [9:0]           w_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_words[g] = bus.data[10*g +: 10];
  end

`ifdef TX_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [OW-1:0] ptr_q, ptr_d;

  assign w_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && w_found) begin
      ptr_d = (w_winner == C_LAST) ? '0 : w_winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Search from w_ptr upward, wrapping modulo NUM_REQ; first set bit wins.
  always_comb begin
    logic [OW:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, w_ptr} + (OW + 1)'(k);
      if (idx >= C_NUM_REQ) begin
        idx = idx - C_NUM_REQ;
      end
      if (!w_found && bus.req[idx[OW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swout_d = swout_q;
    ack_d   = '0;
    start_d = 1'b0;
    busy_d  = busy_q;
    owner_d = owner_q;

    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          swout_d          = w_words[w_winner];
          ack_d[w_winner]  = 1'b1;
          start_d          = 1'b1;
          busy_d           = 1'b1;
          owner_d          = w_winner;
          cnt_d            = C_FRAME_LOAD;
          state_d          = S_SEND;
        end
      end

      S_SEND: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = C_GAP_LOAD;
            state_d = S_GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      swout_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      swout_q <= swout_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.start = start_q;
  assign bus.swout = swout_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

endmodule

`default_nettype wire

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin scheduler that shares the single serial Transmiter between several data requesters in the data transmission unit. Requesters present a 10-bit word and a request. The block grants one requester, latches its word onto the Transmiter's parallel input, and fires Start. It then holds the link busy for a fixed frame time plus an inter-frame gap before serving the next requester.

## Interface
- NumReq, 4, number of requesters (2..8)
- FrameCycles, 5500, CLK cycles one frame occupies the Transmiter (≥1)
- GapCycles, 500, idle CLK cycles enforced after each frame (≥0)
- CLK  in  1  system clock, all logic on rising edge
- RSTn  in  1  asynchronous, active-low reset
- Req  in  NumReq  per-requester request level; bit i = requester i
- Data  in  10*NumReq  requester words; requester i at [10i+9:10i]
- Ack  out  NumReq  one-hot, one-cycle pulse: word of requester i latched
- Start  out  1  one-cycle start pulse to Transmiter
- SWOut  out  10  word to Transmiter SWIn, stable for whole frame + gap
- Busy  out  1  high from grant until end of gap
- Owner  out  clog2(NumReq)  index of last granted requester

## Operation
- States: IDLE, SEND, GAP. Internal down-counter (width from max(FrameCycles,GapCycles)) and round-robin pointer Ptr.
- IDLE: if Req==0, stay. Otherwise winner = first set Req bit searching Ptr, Ptr+1, …, wrapping mod NumReq. On that edge: SWOut←Data[winner], Ack[winner]←1, Start←1, Busy←1, Owner←winner, Ptr←(winner+1) mod NumReq, counter←FrameCycles-1, state←SEND.
- SEND: Start and Ack return to 0 after one cycle. Counter decrements each cycle. At counter==0: if GapCycles>0, then counter←GapCycles-1 and state←GAP; else Busy←0 and state←IDLE.
- GAP: counter decrements. At counter==0: Busy←0, state←IDLE.
- Req is sampled only in IDLE. Requests arriving in SEND/GAP wait. A Req dropped before grant is ignored without an error.
- Requester protocol: hold Req and Data stable until Ack. After Ack, either deassert Req or present the next word. Data is not sampled after the grant edge.
- SWOut holds the last word in IDLE. It is never changed except at a grant.

## Timing
- Reset (RSTn low, asynchronous): state IDLE, Start=0, Ack=0, Busy=0, SWOut=0, Owner=0, Ptr=0, counter=0. Reset mid-frame aborts immediately. The next grant is allowed on the first edge after RSTn rises.
- Grant latency: Req seen high at edge k in IDLE → Ack, Start and Busy high in cycle after edge k.
- Busy stays high exactly FrameCycles+GapCycles cycles per grant.
- Back-to-back: with Req held, the next Start comes FrameCycles+GapCycles+1 cycles after the previous one (one IDLE cycle between grants).
- Simultaneous requests: exactly one Ack bit per grant. Every continuously requesting requester is granted within NumReq grants.
- Ptr wraps from NumReq-1 to 0.

## Configuration
- TX_ARB_FIXED_PRIO_EN defined: the search always starts at index 0, so the lowest index wins. Ptr is not implemented and Owner still reports the winner.
- Not defined: round-robin as specified above.

## Test plan
Bench parameters: NumReq=4, FrameCycles=8, GapCycles=2.

- Reset, then Req=0000 for 50 cycles → Start, Ack and Busy stay 0; SWOut=0.
- Req=0100, Data[2]=10'h2A5 → one cycle later Start=1 and Ack=0100 for one cycle, SWOut=10'h2A5; Busy high 10 cycles, then low.
- Req=1111 held, distinct words → grants in order 0,1,2,3,0 with Starts 11 cycles apart. With TX_ARB_FIXED_PRIO_EN, every grant goes to 0.
- Req=0010 raised during SEND of requester 0 → no Ack until GAP ends; granted on the first IDLE edge.
- RSTn pulsed low at cycle 4 of SEND → all outputs reset immediately; Req=0001 held → new Start one cycle after RSTn rises.
- GapCycles=0 build, Req=0001 held → Busy high 8 cycles, Starts 9 cycles apart.
